// File: rtl/mod_mult_if.sv
// mod_mult_if: start/end pulse handshake and operand bus for the modular multiplier
interface mod_mult_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
);
  logic mm_start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] modulus;
  logic mm_end;
  logic [WIDTH-1:0] mm_out;
  logic mm_err;
  modport master(output mm_start, len, a_in, b_in, modulus, input mm_end, mm_out, mm_err);
  modport slave(input mm_start, len, a_in, b_in, modulus, output mm_end, mm_out, mm_err);
endinterface

// File: rtl/mod_mult.sv
// mod_mult: MSB-first interleaved shift-add (a*b) mod n; define MM_ERR_CHECK_EN for operand range checking
module mod_mult #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic rst,
  mod_mult_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int WL = LEN_W > CW ? LEN_W : CW;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, n_r, bsh;
  logic [WIDTH:0] r, nx, d, ds, s, t;
  logic [WL-1:0] len_x, len_c;
  assign len_x = WL'(bus.len);
  assign len_c = len_x > WL'(WIDTH) ? WL'(WIDTH) : len_x;
  assign nx = {1'b0, n_r};
  assign bsh = b_r >> cnt;
  assign d = r << 1;
  assign ds = d >= nx ? d - nx : d;
  assign s = bsh[0] ? ds + {1'b0, a_r} : ds;
  assign t = s >= nx ? s - nx : s;
`ifdef MM_ERR_CHECK_EN
  logic bad, err_r;
  assign bad = bus.modulus == '0 || bus.a_in >= bus.modulus || bus.b_in >= bus.modulus;
  // error flag latched at start, published with the completion pulse
  always_ff @(posedge clk)
    if (rst) begin
      err_r <= 1'b0;
      bus.mm_err <= 1'b0;
    end else begin
      if (state == IDLE && bus.mm_start) err_r <= bad;
      if (state == DONE) bus.mm_err <= err_r;
    end
`else
  logic bad;
  assign bad = 1'b0;
  assign bus.mm_err = 1'b0;
`endif
  // control FSM and accumulator; a rejected operation leaves R at 0 so mm_out reads 0
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      r <= '0;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      n_r <= '0;
      bus.mm_end <= 1'b0;
      bus.mm_out <= '0;
    end else begin
      bus.mm_end <= 1'b0;
      case (state)
        IDLE:
          if (bus.mm_start) begin
            a_r <= bus.a_in;
            b_r <= bus.b_in;
            n_r <= bus.modulus;
            r <= '0;
            cnt <= len_c == '0 ? '0 : CW'(len_c - WL'(1));
            state <= (len_c == '0 || bad) ? DONE : ITER;
          end
        ITER: begin
          r <= t;
          cnt <= cnt - CW'(1);
          state <= cnt == '0 ? DONE : ITER;
        end
        default: begin
          bus.mm_end <= 1'b1;
          bus.mm_out <= r[WIDTH-1:0];
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/mod_mult.md
Name: mod_mult

Overview:
- Interleaved shift-add modular multiplier: computes (a_in * b_in) mod modulus, MSB-first over `len` bits of b_in.
- Sits directly downstream of the long-division reducer. The reducer's residues (< modulus) are its operands; its result feeds the modular-exponentiation sequencer.
- Uses the same start/end pulse handshake as the reducer.

Parameters:
- WIDTH, 32, operand/modulus/result width in bits.
- LEN_W, 8, width of the `len` input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mm_start  in  1  start pulse; sampled only in IDLE.
- len  in  LEN_W  number of b_in bits processed (bits len-1..0); values > WIDTH clamp to WIDTH.
- a_in  in  WIDTH  multiplicand; must be < modulus.
- b_in  in  WIDTH  multiplier; must be < modulus.
- modulus  in  WIDTH  modulus n.
- mm_end  out  1  one-cycle completion pulse.
- mm_out  out  WIDTH  result; held until the next completion.
- mm_err  out  1  operand error flag; valid with mm_end.

Behaviour:
- Reset: at any clock edge with rst=1, state←IDLE and mm_end=0, mm_out=0, mm_err=0, internal R=0, counter=0. Reset mid-operation aborts it with no mm_end.
- States: IDLE, ITER, DONE.
- IDLE, mm_start=1 at edge E0:
  - Capture a_in, b_in, modulus and clamped len into internal registers; R←0.
  - If clamped len=0: go to DONE with R=0.
  - Otherwise: counter←len-1, go to ITER.
  - Inputs may change after E0.
- ITER, one bit per cycle (R is WIDTH+1 bits internally; no overflow because R<n):
  - T = 2R; if T ≥ n then T = T − n.
  - If b[counter] = 1 then T = T + a; if T ≥ n then T = T − n.
  - R ← T.
  - If counter = 0, go to DONE; otherwise decrement counter.
- DONE, one cycle: registered mm_out←R[WIDTH-1:0], mm_end=1 on the following edge, then IDLE.
- Latency: mm_end rises at edge E0+len+1 and is high for exactly one cycle. For len=0, mm_end rises at E0+1.
- mm_start in ITER or DONE is ignored: no queueing and no effect on the current operation.
- mm_start held high continuously: a new operation starts on the first IDLE cycle after DONE.
- mm_out and mm_err change only at the edge that raises mm_end, or at reset.

Optional Feature:
- Macro: MM_ERR_CHECK_EN.
- Defined:
  - At E0, if modulus=0, a_in ≥ modulus or b_in ≥ modulus, skip ITER and go directly to DONE.
  - That completion has mm_out=0 and mm_err=1, with mm_end at E0+1.
  - A valid operation clears mm_err to 0 at its completion.
- Undefined: mm_err tied 0. Out-of-range operands give an unspecified mm_out, but latency is still len+1 and the FSM still returns to IDLE.

Test Plan:
- Typical: n=128255609, a=100000000, b=3, len=27 → mm_end exactly 28 cycles after start edge, mm_out=43488782, mm_err=0.
- Max operands: n=128255609, a=b=128255608, len=27 → mm_out=1.
- Small values: n=13, a=7, b=9, len=4 → mm_out=11, 5-cycle latency. Repeat with len=40 (clamped to 32) → mm_out=11, latency 33.
- len=0 (any operands) → mm_end at E0+1, mm_out=0. Also pulse mm_start mid-ITER → ignored; single mm_end, correct result.
- Assert rst for one cycle mid-ITER → no mm_end, outputs 0. A following start with n=13, a=7, b=9, len=4 → mm_out=11.
- With MM_ERR_CHECK_EN: modulus=0 → mm_end at E0+1, mm_err=1, mm_out=0. Next, n=13, a=13, b=1 → mm_err=1. Then a valid n=13, a=7, b=9, len=4 → mm_err=0, mm_out=11.
